// File: rtl/float_to_int_if.sv
// Valid/ready bundle for the float-to-int converter: float operand in, integer result plus flags out.
// slave is the converter's view, master is the producer/consumer view.
interface float_to_int_if #(
  parameter int OUT_W = 24
);
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      float_in;
  logic             round_mode;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;
  logic             out_ovf;
  logic             out_nan;
  logic             out_inexact;

  modport slave (
    input  in_valid, float_in, round_mode, out_ready,
    output in_ready, out_valid, out_data, out_ovf, out_nan, out_inexact
  );

  modport master (
    output in_valid, float_in, round_mode, out_ready,
    input  in_ready, out_valid, out_data, out_ovf, out_nan, out_inexact
  );
endinterface

// File: rtl/float_to_int_pipe.sv
// Two-stage binary32 -> OUT_W-bit integer converter with saturation and NaN/overflow/inexact flags.
// Define FLOAT_TO_INT_RNE_EN to honour round_mode (round-nearest-even); otherwise it always truncates.
module float_to_int_pipe #(
  parameter int OUT_W  = 24,
  parameter bit SIGNED = 1'b0
) (
  input  logic         clk,
  input  logic         rst_n,
  float_to_int_if.slave bus
);

  typedef enum logic [1:0] {CLS_ZERO, CLS_NORMAL, CLS_INF, CLS_NAN} cls_t;

  localparam logic [32:0] UMAX     = (33'd1 << OUT_W) - 33'd1;
  localparam logic [32:0] SMAX     = (33'd1 << (OUT_W - 1)) - 33'd1;
  localparam logic [32:0] SMIN_MAG = 33'd1 << (OUT_W - 1);

  logic             s1_valid;
  logic             s1_sign;
  logic signed [8:0] s1_e;
  logic [23:0]      s1_sig;
  cls_t             s1_class;
`ifdef FLOAT_TO_INT_RNE_EN
  logic             s1_rnd;
`endif
  logic             s2_valid;
  logic [OUT_W-1:0] data_reg;
  logic             ovf_reg;
  logic             nan_reg;
  logic             inexact_reg;

  logic adv1, adv2;
  assign adv2 = !s2_valid || bus.out_ready;
  assign adv1 = !s1_valid || adv2;

  assign bus.in_ready    = rst_n && adv1;
  assign bus.out_valid   = s2_valid;
  assign bus.out_data    = data_reg;
  assign bus.out_ovf     = ovf_reg;
  assign bus.out_nan     = nan_reg;
  assign bus.out_inexact = inexact_reg;

  // Stage-1 decode of the incoming operand
  logic [7:0]        in_exp;
  logic [22:0]       in_mant;
  logic signed [8:0] in_e;
  cls_t              in_class;

  always_comb begin
    in_exp   = bus.float_in[30:23];
    in_mant  = bus.float_in[22:0];
    in_e     = $signed({1'b0, in_exp}) - 9'sd127;
    in_class = CLS_NORMAL;
    if (in_exp == 8'd0)
      in_class = CLS_ZERO;
    else if (in_exp == 8'hFF)
      in_class = (in_mant != 23'd0) ? CLS_NAN : CLS_INF;
  end

  // Stage-2 shift, round and range check
  logic [4:0]       rsh;
  logic [3:0]       lsh;
  logic [48:0]      shifted;
  logic [23:0]      m_trunc;
  logic             guard, sticky;
  logic [24:0]      m_round;
  logic [32:0]      mag;
  logic             huge;
  logic             frac_lost;
  logic [OUT_W-1:0] pos_max, neg_min;
  logic [OUT_W-1:0] res_data;
  logic             res_ovf, res_nan, res_inexact;

  always_comb begin
    rsh     = 5'(9'sd23 - s1_e);
    lsh     = 4'(s1_e - 9'sd23);
    shifted = {s1_sig, 25'd0} >> rsh;
    m_trunc = shifted[48:25];
    guard   = shifted[24];
    sticky  = |shifted[23:0];
    // Below 0.5 every significand bit is discarded; the hidden one makes sticky certain
    if (s1_e < -9'sd1) begin
      m_trunc = 24'd0;
      guard   = 1'b0;
      sticky  = 1'b1;
    end
`ifdef FLOAT_TO_INT_RNE_EN
    m_round = {1'b0, m_trunc} + 25'(s1_rnd & guard & (sticky | m_trunc[0]));
`else
    m_round = {1'b0, m_trunc};
`endif
    huge      = s1_e > 9'sd31;
    frac_lost = (s1_e <= 9'sd23) && (guard || sticky);
    if (s1_e > 9'sd23)
      mag = {9'd0, s1_sig} << lsh;
    else
      mag = {8'd0, m_round};

    pos_max = SIGNED ? SMAX[OUT_W-1:0] : UMAX[OUT_W-1:0];
    neg_min = SIGNED ? SMIN_MAG[OUT_W-1:0] : {OUT_W{1'b0}};

    res_data    = '0;
    res_ovf     = 1'b0;
    res_nan     = 1'b0;
    res_inexact = 1'b0;
    case (s1_class)
      CLS_ZERO: res_inexact = |s1_sig[22:0];
      CLS_NAN:  res_nan = 1'b1;
      CLS_INF: begin
        res_ovf  = 1'b1;
        res_data = s1_sign ? neg_min : pos_max;
      end
      default: begin
        res_inexact = frac_lost;
        if (SIGNED) begin
          if (!s1_sign) begin
            if (huge || mag > SMAX) begin
              res_data = pos_max;
              res_ovf  = 1'b1;
            end else
              res_data = mag[OUT_W-1:0];
          end else begin
            if (huge || mag > SMIN_MAG) begin
              res_data = neg_min;
              res_ovf  = 1'b1;
            end else
              res_data = -mag[OUT_W-1:0];
          end
        end else begin
          if (s1_sign)
            res_ovf = huge || (mag != 33'd0);
          else if (huge || mag > UMAX) begin
            res_data = pos_max;
            res_ovf  = 1'b1;
          end else
            res_data = mag[OUT_W-1:0];
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid    <= 1'b0;
      s1_sign     <= 1'b0;
      s1_e        <= '0;
      s1_sig      <= '0;
      s1_class    <= CLS_ZERO;
`ifdef FLOAT_TO_INT_RNE_EN
      s1_rnd      <= 1'b0;
`endif
      s2_valid    <= 1'b0;
      data_reg    <= '0;
      ovf_reg     <= 1'b0;
      nan_reg     <= 1'b0;
      inexact_reg <= 1'b0;
    end else begin
      if (adv1) begin
        s1_valid <= bus.in_valid;
        if (bus.in_valid) begin
          s1_sign  <= bus.float_in[31];
          s1_e     <= in_e;
          s1_sig   <= {in_exp != 8'd0, in_mant};
          s1_class <= in_class;
`ifdef FLOAT_TO_INT_RNE_EN
          s1_rnd   <= bus.round_mode;
`endif
        end
      end
      if (adv2) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          data_reg    <= res_data;
          ovf_reg     <= res_ovf;
          nan_reg     <= res_nan;
          inexact_reg <= res_inexact;
        end
      end
    end
  end

endmodule

// File: tb/tb_float_to_int_pipe.sv
// Scoreboard bench: directed vectors push expected results, per-DUT monitors pop and compare on output handshakes.
module tb_float_to_int_pipe;
  localparam int W = 24;

`ifdef FLOAT_TO_INT_RNE_EN
  localparam bit RNE = 1'b1;
`else
  localparam bit RNE = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  float_to_int_if #(.OUT_W(W)) bus_u ();
  float_to_int_if #(.OUT_W(W)) bus_s ();

  float_to_int_pipe #(.OUT_W(W), .SIGNED(1'b0)) dut_u (.clk(clk), .rst_n(rst_n), .bus(bus_u.slave));
  float_to_int_pipe #(.OUT_W(W), .SIGNED(1'b1)) dut_s (.clk(clk), .rst_n(rst_n), .bus(bus_s.slave));

  typedef struct {
    logic [31:0]  f;
    logic [W-1:0] data;
    logic         ovf;
    logic         nan;
    logic         inx;
  } exp_t;

  exp_t q_u[$];
  exp_t q_s[$];
  int n_cmp = 0;
  int n_err = 0;

  function automatic void expect_v(string name, logic [31:0] got, logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endfunction

  function automatic void check_item(string tag, exp_t e, logic [W-1:0] d, logic o, logic n, logic x);
    n_cmp++;
    if ({d, o, n, x} !== {e.data, e.ovf, e.nan, e.inx}) begin
      n_err++;
      $display("FAIL %s f=%08h got data=%06h ovf=%0b nan=%0b inx=%0b want data=%06h ovf=%0b nan=%0b inx=%0b",
               tag, e.f, d, o, n, x, e.data, e.ovf, e.nan, e.inx);
    end else
      $display("ok   %s f=%08h data=%06h ovf=%0b nan=%0b inx=%0b", tag, e.f, d, o, n, x);
  endfunction

  always @(negedge clk) begin : mon_u
    exp_t e;
    if (rst_n && bus_u.out_valid && bus_u.out_ready) begin
      if (q_u.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unsigned unexpected output data=%06h", bus_u.out_data);
      end else begin
        e = q_u.pop_front();
        check_item("unsigned", e, bus_u.out_data, bus_u.out_ovf, bus_u.out_nan, bus_u.out_inexact);
      end
    end
  end

  always @(negedge clk) begin : mon_s
    exp_t e;
    if (rst_n && bus_s.out_valid && bus_s.out_ready) begin
      if (q_s.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL signed unexpected output data=%06h", bus_s.out_data);
      end else begin
        e = q_s.pop_front();
        check_item("signed  ", e, bus_s.out_data, bus_s.out_ovf, bus_s.out_nan, bus_s.out_inexact);
      end
    end
  end

  function automatic logic rdy(bit s);
    return s ? bus_s.in_ready : bus_u.in_ready;
  endfunction

  // Called just after a rising edge; returns 1ns after the edge that accepted the item
  task automatic send(bit s, logic [31:0] f, bit rm, logic [W-1:0] d, bit o, bit n, bit x);
    exp_t e;
    int t;
    e = '{f: f, data: d, ovf: o, nan: n, inx: x};
    t = 0;
    if (s) begin
      bus_s.in_valid = 1'b1; bus_s.float_in = f; bus_s.round_mode = rm;
    end else begin
      bus_u.in_valid = 1'b1; bus_u.float_in = f; bus_u.round_mode = rm;
    end
    @(negedge clk);
    while (!rdy(s) && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) begin
      n_cmp++;
      n_err++;
      $display("FAIL send timeout f=%08h in_ready=0 want=1", f);
      @(posedge clk);
    end else begin
      @(posedge clk);
      if (s) q_s.push_back(e);
      else   q_u.push_back(e);
    end
    #1;
    if (s) bus_s.in_valid = 1'b0;
    else   bus_u.in_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((q_u.size() != 0 || q_s.size() != 0) && t < 100) begin
      @(negedge clk);
      t++;
    end
    expect_v("drain pending", 32'(q_u.size() + q_s.size()), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    bus_u.in_valid = 1'b0; bus_u.float_in = '0; bus_u.round_mode = 1'b0; bus_u.out_ready = 1'b1;
    bus_s.in_valid = 1'b0; bus_s.float_in = '0; bus_s.round_mode = 1'b0; bus_s.out_ready = 1'b1;
    rst_n = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    expect_v("rst in_ready",  bus_u.in_ready, 0);
    expect_v("rst out_valid", bus_u.out_valid, 0);
    expect_v("rst out_data",  bus_u.out_data, 0);
    expect_v("rst flags",     {bus_u.out_ovf, bus_u.out_nan, bus_u.out_inexact}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Latency on zero
    send(0, 32'h00000000, 0, 24'd0, 0, 0, 0);
    @(negedge clk);
    expect_v("latency cyc1 out_valid", bus_u.out_valid, 0);
    @(negedge clk);
    expect_v("latency cyc2 out_valid", bus_u.out_valid, 1);
    @(posedge clk); #1;

    // Unsigned, OUT_W=24
    send(0, 32'h42280000, 0, 24'd42, 0, 0, 0);
    send(0, 32'h41000000, 0, 24'd8, 0, 0, 0);
    send(0, 32'h4996B438, 0, 24'd1234567, 0, 0, 0);
    send(0, 32'h40200000, 1, 24'd2, 0, 0, 1);
    send(0, 32'h40600000, 1, RNE ? 24'd4 : 24'd3, 0, 0, 1);
    send(0, 32'h40200000, 0, 24'd2, 0, 0, 1);
    send(0, 32'h40600000, 0, 24'd3, 0, 0, 1);
    send(0, 32'h3FC00000, 1, RNE ? 24'd2 : 24'd1, 0, 0, 1);
    send(0, 32'h3F000000, 1, 24'd0, 0, 0, 1);
    send(0, 32'h3F400000, 1, RNE ? 24'd1 : 24'd0, 0, 0, 1);
    send(0, 32'h4B7FFFFF, 0, 24'hFFFFFF, 0, 0, 0);
    send(0, 32'h4B800000, 0, 24'hFFFFFF, 1, 0, 0);
    send(0, 32'h4F800000, 0, 24'hFFFFFF, 1, 0, 0);
    send(0, 32'hC2280000, 0, 24'd0, 1, 0, 0);
    send(0, 32'hBF000000, 0, 24'd0, 0, 0, 1);
    send(0, 32'hBF400000, 1, 24'd0, RNE, 0, 1);
    send(0, 32'h7FC00000, 0, 24'd0, 0, 1, 0);
    send(0, 32'hFF800000, 0, 24'd0, 1, 0, 0);
    send(0, 32'h7F800000, 0, 24'hFFFFFF, 1, 0, 0);
    send(0, 32'h00000001, 0, 24'd0, 0, 0, 1);
    send(0, 32'h80000000, 0, 24'd0, 0, 0, 0);

    // Signed, OUT_W=24
    send(1, 32'hC2280000, 0, 24'hFFFFD6, 0, 0, 0);
    send(1, 32'hCB000000, 0, 24'h800000, 0, 0, 0);
    send(1, 32'h4B000000, 0, 24'h7FFFFF, 1, 0, 0);
    send(1, 32'hCB000001, 0, 24'h800000, 1, 0, 0);
    send(1, 32'h4AFFFFFF, 1, 24'h7FFFFF, RNE, 0, 1);
    send(1, 32'h4AFFFFFF, 0, 24'h7FFFFF, 0, 0, 1);
    send(1, 32'hC0200000, 0, 24'hFFFFFE, 0, 0, 1);
    send(1, 32'hC0600000, 1, RNE ? 24'hFFFFFC : 24'hFFFFFD, 0, 0, 1);
    send(1, 32'hFF800000, 0, 24'h800000, 1, 0, 0);
    send(1, 32'h7F800000, 0, 24'h7FFFFF, 1, 0, 0);
    send(1, 32'h7FC00000, 0, 24'd0, 0, 1, 0);
    drain();

    // Backpressure: two items fill the pipe, two more wait for release
    bus_u.out_ready = 1'b0;
    send(0, 32'h42280000, 0, 24'd42, 0, 0, 0);
    send(0, 32'h41000000, 0, 24'd8, 0, 0, 0);
    fork
      begin
        send(0, 32'h4996B438, 0, 24'd1234567, 0, 0, 0);
        send(0, 32'hC2280000, 0, 24'd0, 1, 0, 0);
      end
      begin
        repeat (6) begin
          @(negedge clk);
          expect_v("stall in_ready", bus_u.in_ready, 0);
          expect_v("stall out_data", bus_u.out_data, 24'd42);
        end
        @(posedge clk); #1;
        bus_u.out_ready = 1'b1;
      end
    join
    drain();

    // Reset while an item is in flight discards it
    send(0, 32'h41000000, 0, 24'd8, 0, 0, 0);
    rst_n = 1'b0;
    q_u.delete();
    @(negedge clk);
    expect_v("midrst out_valid", bus_u.out_valid, 0);
    expect_v("midrst in_ready", bus_u.in_ready, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    expect_v("postrst out_valid", bus_u.out_valid, 0);
    @(posedge clk); #1;
    send(0, 32'h42280000, 0, 24'd42, 0, 0, 0);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end
endmodule
